uart_tx: RTL and testbench

- Serial transmitter of the APB-UART, directly downstream of the APB register block.
- Consumes the block's TX data and configuration outputs: tx_data, data bit count, stop bit count, parity enable, parity type and start_tx.
- Serialises one asynchronous UART frame on tx_o.
- Returns tx_done, which the register block samples into the status register.

---
 rtl/uart_tx_if.sv | 22 ++
 rtl/uart_tx.sv | 175 +++++++++++++++++
 tb/tb_uart_tx.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// TX-side connection between the APB register block and the serial transmitter:
// latched configuration, the start request level, and busy/done status.
interface uart_tx_if;
  logic [31:0] tx_data_i;
  logic [1:0]  data_bit_num_i;
  logic        stop_bit_num_i;
  logic        parity_en_i;
  logic        parity_type_i;
  logic        start_tx_i;
  logic        tx_busy_o;
  logic        tx_done_o;

  modport master (
    output tx_data_i, data_bit_num_i, stop_bit_num_i, parity_en_i, parity_type_i, start_tx_i,
    input  tx_busy_o, tx_done_o
  );

  modport slave (
    input  tx_data_i, data_bit_num_i, stop_bit_num_i, parity_en_i, parity_type_i, start_tx_i,
    output tx_busy_o, tx_done_o
  );
endinterface

// File: rtl/uart_tx.sv
// UART serial transmitter: one start bit, 5..8 data bits LSB first, optional
// even/odd parity, 1 or 2 stop bits. tx_o is registered and idles high.
module uart_tx #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave bus,
  output logic     tx_o
);

  localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic          start_prev;
  logic          start_req;
  logic          accept, finish;
  logic          tx_next;
  logic          done_q, done_n;

  logic [7:0]    sh_data;
  logic [1:0]    sh_bits;
  logic          sh_stop2;
  logic          sh_pen;
  logic          sh_odd;

  logic          baud_last;
  logic [2:0]    last_bit;
  logic [7:0]    data_mask;
  logic          parity_bit;

  logic          unused_hi;
  assign unused_hi = ^bus.tx_data_i[31:8];

  assign start_req = bus.start_tx_i & ~start_prev;
  assign baud_last = (baud_cnt == BAUD_LAST);
  assign last_bit  = 3'd4 + {1'b0, sh_bits};

  always_comb begin
    data_mask = 8'hFF;
    case (sh_bits)
      2'd0:    data_mask = 8'h1F;
      2'd1:    data_mask = 8'h3F;
      2'd2:    data_mask = 8'h7F;
      default: data_mask = 8'hFF;
    endcase
  end

  // Untransmitted high bits are masked out so they never enter the parity.
  assign parity_bit = (^(sh_data & data_mask)) ^ sh_odd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      start_prev <= 1'b1;
      tx_o       <= 1'b1;
      done_q     <= 1'b0;
      sh_data    <= '0;
      sh_bits    <= '0;
      sh_stop2   <= 1'b0;
      sh_pen     <= 1'b0;
      sh_odd     <= 1'b0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_cnt_n;
      bit_cnt    <= bit_cnt_n;
      start_prev <= bus.start_tx_i;
      tx_o       <= tx_next;
      done_q     <= done_n;
      if (accept) begin
        sh_data  <= bus.tx_data_i[7:0];
        sh_bits  <= bus.data_bit_num_i;
        sh_stop2 <= bus.stop_bit_num_i;
        sh_pen   <= bus.parity_en_i;
        sh_odd   <= bus.parity_type_i;
      end
    end
  end

  // In STOP the bit counter distinguishes the first and second stop bit.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start_req) begin
          state_n    = START;
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
          accept     = 1'b1;
        end
      end
      START: begin
        if (baud_last) begin
          state_n    = DATA;
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
        end else begin
          baud_cnt_n = baud_cnt + CW'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_cnt_n = '0;
          if (bit_cnt == last_bit) begin
            bit_cnt_n = '0;
            state_n   = sh_pen ? PARITY : STOP;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end else begin
          baud_cnt_n = baud_cnt + CW'(1);
        end
      end
      PARITY: begin
        if (baud_last) begin
          state_n    = STOP;
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
        end else begin
          baud_cnt_n = baud_cnt + CW'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_cnt_n = '0;
          if (sh_stop2 && (bit_cnt == 3'd0)) begin
            bit_cnt_n = 3'd1;
          end else begin
            bit_cnt_n = '0;
            state_n   = IDLE;
            finish    = 1'b1;
          end
        end else begin
          baud_cnt_n = baud_cnt + CW'(1);
        end
      end
      default: begin
        state_n    = IDLE;
        baud_cnt_n = '0;
        bit_cnt_n  = '0;
      end
    endcase
  end

  // Line level is derived from the next state so tx_o changes with the state.
  always_comb begin
    tx_next = 1'b1;
    done_n  = done_q;
    case (state_n)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = sh_data[bit_cnt_n];
      PARITY:  tx_next = parity_bit;
      STOP:    tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
    if (accept) done_n = 1'b0;
    if (finish) done_n = 1'b1;
  end

  assign bus.tx_busy_o = (state != IDLE);
  assign bus.tx_done_o = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with BAUD_DIV=4: frames are compared bit-time by
// bit-time against hand-built {stop, parity, data, start} patterns.
module tb_uart_tx;

  localparam int unsigned BD = 4;

  logic clk;
  logic reset;
  logic tx_o;
  int   checks;
  int   errors;

  uart_tx_if bus ();

  uart_tx #(.BAUD_DIV(BD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .tx_o  (tx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // exp holds the frame with bit 0 = start bit, sent in ascending index order.
  task automatic send_frame(input string tag, input logic [31:0] data, input logic [1:0] dbn,
                            input logic stop2, input logic pen, input logic podd,
                            input logic [11:0] exp, input int f, input bit disturb);
    int cyc;
    bus.tx_data_i      = data;
    bus.data_bit_num_i = dbn;
    bus.stop_bit_num_i = stop2;
    bus.parity_en_i    = pen;
    bus.parity_type_i  = podd;
    bus.start_tx_i     = 1'b1;
    cyc = 0;
    for (int b = 0; b < f; b++) begin
      for (int c = 0; c < int'(BD); c++) begin
        step();
        cyc++;
        check({tag, "_tx"}, 32'(tx_o), 32'(exp[b]));
        if (c == 0) begin
          check({tag, "_busy"}, 32'(bus.tx_busy_o), 32'd1);
          check({tag, "_done_low"}, 32'(bus.tx_done_o), 32'd0);
        end
        if (disturb) begin
          if (cyc == 10) begin
            bus.tx_data_i      = ~data;
            bus.data_bit_num_i = ~dbn;
            bus.stop_bit_num_i = ~stop2;
            bus.parity_en_i    = ~pen;
            bus.parity_type_i  = ~podd;
          end
          if (cyc == 12) bus.start_tx_i = 1'b0;
          if (cyc == 14) bus.start_tx_i = 1'b1;
        end
      end
    end
    step();
    check({tag, "_done"}, 32'(bus.tx_done_o), 32'd1);
    check({tag, "_idle_busy"}, 32'(bus.tx_busy_o), 32'd0);
    check({tag, "_idle_tx"}, 32'(tx_o), 32'd1);
    if (disturb) begin
      for (int i = 0; i < 12; i++) begin
        step();
        check({tag, "_no_refire"}, {30'd0, bus.tx_busy_o, tx_o}, 32'd1);
      end
      check({tag, "_done_hold"}, 32'(bus.tx_done_o), 32'd1);
    end
    bus.start_tx_i = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.tx_data_i      = '0;
    bus.data_bit_num_i = 2'b11;
    bus.stop_bit_num_i = 1'b0;
    bus.parity_en_i    = 1'b0;
    bus.parity_type_i  = 1'b0;
    bus.start_tx_i     = 1'b1;

    step();
    step();
    check("rst_tx", 32'(tx_o), 32'd1);
    check("rst_busy", 32'(bus.tx_busy_o), 32'd0);
    check("rst_done", 32'(bus.tx_done_o), 32'd0);

    // start_tx high through reset release must not launch a frame
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("hold_after_rst", {30'd0, bus.tx_busy_o, tx_o}, 32'd1);
    end
    bus.start_tx_i = 1'b0;
    step();

    // 8N1 0xA5
    send_frame("8n1", 32'h0000_00A5, 2'b11, 1'b0, 1'b0, 1'b0, {2'b00, 10'b1101001010}, 10, 1'b0);
    // 8E1 0xA5: four ones -> parity 0
    send_frame("8e1", 32'h0000_00A5, 2'b11, 1'b0, 1'b1, 1'b0, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 1'b0);
    // 8O1 0xA5: parity 1
    send_frame("8o1", 32'h0000_00A5, 2'b11, 1'b0, 1'b1, 1'b1, {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, 1'b0);
    // 5E1 0xFF with junk above bit 7: five ones -> parity 1, frame 8 bits
    send_frame("5e1", 32'hDEAD_BEFF, 2'b00, 1'b0, 1'b1, 1'b0, {4'b0000, 1'b1, 1'b1, 5'b11111, 1'b0}, 8, 1'b0);
    // 7N2 0x5A: two stop bits, frame 10 bits
    send_frame("7n2", 32'h0000_005A, 2'b10, 1'b1, 1'b0, 1'b0, {2'b00, 2'b11, 7'h5A, 1'b0}, 10, 1'b0);
    // 6O2 0x2C (6 bits 101100, three ones -> odd parity 0)
    send_frame("6o2", 32'h0000_002C, 2'b01, 1'b1, 1'b1, 1'b1, {2'b00, 2'b11, 1'b0, 6'h2C, 1'b0}, 10, 1'b0);
    // mid-frame config changes and start re-pulse are ignored
    send_frame("dist", 32'h0000_0036, 2'b11, 1'b0, 1'b0, 1'b0, {2'b00, 1'b1, 8'h36, 1'b0}, 10, 1'b1);
    // fresh edge after the disturbed frame launches normally
    send_frame("after", 32'h0000_0081, 2'b11, 1'b0, 1'b0, 1'b0, {2'b00, 1'b1, 8'h81, 1'b0}, 10, 1'b0);

    // reset in the middle of an 8N1 frame
    bus.tx_data_i      = 32'h0000_0000;
    bus.data_bit_num_i = 2'b11;
    bus.stop_bit_num_i = 1'b0;
    bus.parity_en_i    = 1'b0;
    bus.start_tx_i     = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("pre_rst_busy", 32'(bus.tx_busy_o), 32'd1);
    check("pre_rst_tx", 32'(tx_o), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_tx", 32'(tx_o), 32'd1);
    check("mid_rst_busy", 32'(bus.tx_busy_o), 32'd0);
    check("mid_rst_done", 32'(bus.tx_done_o), 32'd0);
    for (int i = 0; i < 48; i++) begin
      step();
      check("mid_rst_idle", {29'd0, bus.tx_done_o, bus.tx_busy_o, tx_o}, 32'd1);
    end
    bus.start_tx_i = 1'b0;
    step();
    send_frame("post_rst", 32'h0000_00C3, 2'b11, 1'b0, 1'b1, 1'b0, {1'b0, 1'b1, 1'b0, 8'hC3, 1'b0}, 11, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
